// File: rtl/enigma_pkg.sv
// Shared types and constants for the two-port QoS request merger.
package enigma_pkg;

  localparam int BEAT_DW  = 128;
  localparam int BEAT_IDW = 5;
  localparam int BEAT_TW  = BEAT_IDW + 1;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef struct packed {
    logic [BEAT_DW-1:0]  payload;
    logic [BEAT_IDW-1:0] id;
    logic [1:0]          qos;
  } beat_t;

  function automatic logic [BEAT_TW-1:0] make_tid(input logic src, input logic [BEAT_IDW-1:0] id);
    return {src, id};
  endfunction

endpackage

// File: rtl/enigma_fifo.sv
// Small synchronous FIFO holding one producer's beats; full/empty come from a registered count.
module enigma_fifo
  import enigma_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = beat_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/enigma_arb2.sv
// Merges producer ports A and B onto consumer port C: QoS/round-robin selection,
// grant lock under backpressure, one-cycle conflict mask and an outstanding-ID table.
module enigma_arb2
  import enigma_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int DW         = BEAT_DW,
  parameter int IDW        = BEAT_IDW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [DW-1:0]  payload_a,
  input  logic [IDW-1:0] id_a,
  input  logic [1:0]     qos_a,
  input  logic           valid_a,
  output logic           ready_a,
  input  logic [DW-1:0]  payload_b,
  input  logic [IDW-1:0] id_b,
  input  logic [1:0]     qos_b,
  input  logic           valid_b,
  output logic           ready_b,
  output logic [DW-1:0]  payload_c,
  output logic [IDW:0]   id_c,
  output logic [1:0]     qos_c,
  output logic           valid_c,
  input  logic           ready_c,
  input  logic           conflict_c,
  input  logic           release_c,
  input  logic [IDW:0]   releaseid_c,
  output logic           err_rel
);

  localparam int TW   = IDW + 1;
  localparam int NTID = 2 ** TW;

  // Handshakes: a beat moves on an edge where valid & ready are both high; a
  // producer holds its beat until then, and C holds its beat (grant lock) likewise.
  beat_t           head_a, head_b, sel_beat;
  logic            full_a, full_b, empty_a, empty_b;
  logic            push_a, push_b, pop_a, pop_b;
  logic            elig_a, elig_b;
  logic            sel_src, sel_valid;
  logic            accept, conflict;
  logic            grant_lock, grant_src, last_grant;
  logic            mask_a, mask_b;
  logic [NTID-1:0] out_tbl, set_vec, rel_vec;

  assign ready_a = ~full_a;
  assign ready_b = ~full_b;
  assign push_a  = valid_a & ready_a;
  assign push_b  = valid_b & ready_b;

  enigma_fifo #(.DEPTH(FIFO_DEPTH), .T(beat_t)) u_fifo_a (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_a),
    .din   ('{payload: payload_a, id: id_a, qos: qos_a}),
    .pop   (pop_a),
    .head  (head_a),
    .full  (full_a),
    .empty (empty_a)
  );

  enigma_fifo #(.DEPTH(FIFO_DEPTH), .T(beat_t)) u_fifo_b (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_b),
    .din   ('{payload: payload_b, id: id_b, qos: qos_b}),
    .pop   (pop_b),
    .head  (head_b),
    .full  (full_b),
    .empty (empty_b)
  );

  assign elig_a = ~empty_a & ~out_tbl[make_tid(SRC_A, head_a.id)] & ~mask_a;
  assign elig_b = ~empty_b & ~out_tbl[make_tid(SRC_B, head_b.id)] & ~mask_b;

  always_comb begin
    sel_src   = SRC_A;
    sel_valid = 1'b0;
    if (grant_lock) begin
      sel_src   = grant_src;
      sel_valid = (grant_src == SRC_B) ? ~empty_b : ~empty_a;
    end else if (elig_a && elig_b) begin
      sel_valid = 1'b1;
      if (head_a.qos > head_b.qos)      sel_src = SRC_A;
      else if (head_b.qos > head_a.qos) sel_src = SRC_B;
      else                              sel_src = ~last_grant;
    end else if (elig_a) begin
      sel_src   = SRC_A;
      sel_valid = 1'b1;
    end else if (elig_b) begin
      sel_src   = SRC_B;
      sel_valid = 1'b1;
    end
  end

  assign sel_beat  = (sel_src == SRC_B) ? head_b : head_a;
  assign valid_c   = sel_valid;
  assign payload_c = sel_valid ? sel_beat.payload : '0;
  assign id_c      = sel_valid ? make_tid(sel_src, sel_beat.id) : '0;
  assign qos_c     = sel_valid ? sel_beat.qos : '0;

  assign accept   = valid_c & ready_c & ~conflict_c;
  assign conflict = valid_c & ready_c & conflict_c;
  assign pop_a    = accept & (sel_src == SRC_A);
  assign pop_b    = accept & (sel_src == SRC_B);

  // Release clears and accept sets in the same edge; the set is applied last so it wins.
  always_comb begin
    set_vec = '0;
    rel_vec = '0;
    if (accept)    set_vec[id_c] = 1'b1;
    if (release_c) rel_vec[releaseid_c] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_lock <= 1'b0;
      grant_src  <= SRC_A;
      last_grant <= SRC_B;
      mask_a     <= 1'b0;
      mask_b     <= 1'b0;
      out_tbl    <= '0;
      err_rel    <= 1'b0;
    end else begin
      if (valid_c && !ready_c) begin
        grant_lock <= 1'b1;
        grant_src  <= sel_src;
      end else begin
        grant_lock <= 1'b0;
      end
      if (accept) last_grant <= sel_src;
      mask_a  <= conflict & (sel_src == SRC_A);
      mask_b  <= conflict & (sel_src == SRC_B);
      out_tbl <= (out_tbl & ~rel_vec) | set_vec;
      if (release_c && !out_tbl[releaseid_c]) err_rel <= 1'b1;
    end
  end

endmodule

// File: tb/tb_enigma_arb2.sv
// Self-checking bench for enigma_arb2: queue-based reference model, directed scenarios, random traffic.
module tb_enigma_arb2;
  import enigma_pkg::*;

  localparam int DEPTH = 2;
  localparam int DW    = 128;
  localparam int IDW   = 5;
  localparam int NID   = 2 ** IDW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [DW-1:0]  payload_a, payload_b, payload_c;
  logic [IDW-1:0] id_a, id_b;
  logic [1:0]     qos_a, qos_b, qos_c;
  logic           valid_a, valid_b, ready_a, ready_b;
  logic [IDW:0]   id_c, releaseid_c;
  logic           valid_c, ready_c, conflict_c, release_c, err_rel;

  always #5 clk = ~clk;

  enigma_arb2 #(.FIFO_DEPTH(DEPTH), .DW(DW), .IDW(IDW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .payload_a   (payload_a),
    .id_a        (id_a),
    .qos_a       (qos_a),
    .valid_a     (valid_a),
    .ready_a     (ready_a),
    .payload_b   (payload_b),
    .id_b        (id_b),
    .qos_b       (qos_b),
    .valid_b     (valid_b),
    .ready_b     (ready_b),
    .payload_c   (payload_c),
    .id_c        (id_c),
    .qos_c       (qos_c),
    .valid_c     (valid_c),
    .ready_c     (ready_c),
    .conflict_c  (conflict_c),
    .release_c   (release_c),
    .releaseid_c (releaseid_c),
    .err_rel     (err_rel)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-port queues, outstanding set indexed by port*NID+id.
  beat_t exp_q_a[$];
  beat_t exp_q_b[$];
  bit    m_out[2*NID];
  int    m_last;
  bit    m_lock;
  int    m_lock_port;
  bit    m_mask[2];
  bit    m_err;
  bit    pushed_a, pushed_b;

  function automatic int msize(int p);
    return (p == 0) ? exp_q_a.size() : exp_q_b.size();
  endfunction

  function automatic beat_t mhead(int p);
    return (p == 0) ? exp_q_a[0] : exp_q_b[0];
  endfunction

  function automatic bit mcand(int p);
    beat_t h;
    if (msize(p) == 0) return 1'b0;
    h = mhead(p);
    if (m_out[p*NID + int'(h.id)]) return 1'b0;
    return !m_mask[p];
  endfunction

  function automatic void mpick(output bit v, output int p);
    bit c0, c1;
    c0 = mcand(0);
    c1 = mcand(1);
    v = 1'b1;
    p = 0;
    if (m_lock) p = m_lock_port;
    else if (c0 && c1) begin
      if (mhead(0).qos > mhead(1).qos)      p = 0;
      else if (mhead(1).qos > mhead(0).qos) p = 1;
      else                                  p = 1 - m_last;
    end
    else if (c0) p = 0;
    else if (c1) p = 1;
    else v = 1'b0;
  endfunction

  task automatic model_reset();
    exp_q_a.delete();
    exp_q_b.delete();
    for (int i = 0; i < 2*NID; i++) m_out[i] = 1'b0;
    m_last = 1;
    m_lock = 1'b0;
    m_lock_port = 0;
    m_mask[0] = 1'b0;
    m_mask[1] = 1'b0;
    m_err = 1'b0;
    pushed_a = 1'b0;
    pushed_b = 1'b0;
  endtask

  task automatic model_update();
    bit v;
    int p;
    bit ra, rb;
    beat_t h;
    mpick(v, p);
    ra = exp_q_a.size() < DEPTH;
    rb = exp_q_b.size() < DEPTH;
    if (release_c) begin
      if (!m_out[int'(releaseid_c)]) m_err = 1'b1;
      m_out[int'(releaseid_c)] = 1'b0;
    end
    m_mask[0] = 1'b0;
    m_mask[1] = 1'b0;
    if (v && ready_c && !conflict_c) begin
      h = mhead(p);
      m_out[p*NID + int'(h.id)] = 1'b1;
      if (p == 0) void'(exp_q_a.pop_front());
      else        void'(exp_q_b.pop_front());
      m_last = p;
      m_lock = 1'b0;
    end else if (v && ready_c && conflict_c) begin
      m_mask[p] = 1'b1;
      m_lock = 1'b0;
    end else if (v && !ready_c) begin
      m_lock = 1'b1;
      m_lock_port = p;
    end
    pushed_a = valid_a && ra;
    pushed_b = valid_b && rb;
    if (pushed_a) exp_q_a.push_back('{payload: payload_a, id: id_a, qos: qos_a});
    if (pushed_b) exp_q_b.push_back('{payload: payload_b, id: id_b, qos: qos_b});
  endtask

  task automatic compare_all();
    bit v;
    int p;
    beat_t h;
    mpick(v, p);
    chk("ready_a", ready_a, exp_q_a.size() < DEPTH);
    chk("ready_b", ready_b, exp_q_b.size() < DEPTH);
    chk("valid_c", valid_c, v);
    if (v) begin
      h = mhead(p);
      chk("id_c", id_c, p*NID + int'(h.id));
      chk("qos_c", qos_c, h.qos);
      chk("payload_c", payload_c, h.payload);
    end
    chk("err_rel", err_rel, m_err);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    payload_a = '0; id_a = '0; qos_a = '0; valid_a = 1'b0;
    payload_b = '0; id_b = '0; qos_b = '0; valid_b = 1'b0;
    ready_c = 1'b0; conflict_c = 1'b0; release_c = 1'b0; releaseid_c = '0;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    compare_all();
  endtask

  task automatic rel(input logic [IDW:0] t);
    release_c = 1'b1;
    releaseid_c = t;
    step();
    release_c = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    idle_inputs();
    model_reset();
    #1;
    chk("rst_valid_c", valid_c, 0);
    chk("rst_ready_a", ready_a, 1);
    chk("rst_ready_b", ready_b, 1);
    chk("rst_payload_c", payload_c, 0);
    chk("rst_id_c", id_c, 0);
    chk("rst_qos_c", qos_c, 0);
    chk("rst_err_rel", err_rel, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    compare_all();

    // Single beat, one-cycle latency.
    valid_a = 1'b1; id_a = 5'd5; qos_a = 2'd1; payload_a = 128'hDEAD; ready_c = 1'b1;
    step();
    valid_a = 1'b0;
    chk("single_valid", valid_c, 1);
    chk("single_id", id_c, 6'h05);
    chk("single_payload", payload_c, 128'hDEAD);
    step();
    chk("single_gone", valid_c, 0);
    rel(6'h05);
    chk("single_rel_ok", err_rel, 0);

    // QoS priority.
    valid_a = 1'b1; id_a = 5'd1; qos_a = 2'd1; payload_a = 128'hA1;
    valid_b = 1'b1; id_b = 5'd2; qos_b = 2'd3; payload_b = 128'hB2;
    step();
    valid_a = 1'b0; valid_b = 1'b0;
    chk("qos_first", id_c, 6'h22);
    step();
    chk("qos_second", id_c, 6'h01);
    step();
    rel(6'h22);
    rel(6'h01);

    // Round-robin on equal QoS, starting with A after reset.
    do_reset();
    ready_c = 1'b1;
    valid_a = 1'b1; qos_a = 2'd2; id_a = 5'd0; payload_a = 128'h100;
    valid_b = 1'b1; qos_b = 2'd2; id_b = 5'd0; payload_b = 128'h200;
    hs = 0;
    for (int k = 0; k < 12; k++) begin
      if (valid_c && ready_c) begin
        chk("rr_src", id_c[IDW], hs % 2);
        hs++;
      end
      step();
      if (pushed_a) begin id_a = id_a + 1'b1; payload_a = payload_a + 1'b1; end
      if (pushed_b) begin id_b = id_b + 1'b1; payload_b = payload_b + 1'b1; end
    end
    chk("rr_count", hs >= 8, 1);

    // ID hazard blocks only its own port.
    do_reset();
    ready_c = 1'b1;
    valid_a = 1'b1; id_a = 5'd3; qos_a = 2'd0; payload_a = 128'h31;
    step();
    payload_a = 128'h32;
    step();
    valid_a = 1'b0;
    chk("haz_blocked", valid_c, 0);
    valid_b = 1'b1; id_b = 5'd3; qos_b = 2'd0; payload_b = 128'hB3;
    step();
    valid_b = 1'b0;
    chk("haz_b_valid", valid_c, 1);
    chk("haz_b_id", id_c, 6'h23);
    step();
    chk("haz_still_blocked", valid_c, 0);
    rel(6'h03);
    chk("haz_release_valid", valid_c, 1);
    chk("haz_release_id", id_c, 6'h03);
    chk("haz_release_payload", payload_c, 128'h32);
    step();

    // Conflict replay.
    do_reset();
    valid_a = 1'b1; id_a = 5'd4; qos_a = 2'd2; payload_a = 128'hCAFE_0004;
    valid_b = 1'b1; id_b = 5'd6; qos_b = 2'd1; payload_b = 128'hBEEF_0006;
    step();
    valid_a = 1'b0; valid_b = 1'b0;
    chk("cf_first", id_c, 6'h04);
    ready_c = 1'b1; conflict_c = 1'b1;
    step();
    conflict_c = 1'b0;
    chk("cf_other", id_c, 6'h26);
    step();
    chk("cf_replay_id", id_c, 6'h04);
    chk("cf_replay_payload", payload_c, 128'hCAFE_0004);
    step();
    chk("cf_done", valid_c, 0);
    rel(6'h04);
    chk("cf_table_set", err_rel, 0);

    // Backpressure, lock, err_rel and asynchronous reset.
    do_reset();
    valid_a = 1'b1; id_a = 5'd10; qos_a = 2'd0; payload_a = 128'hA10;
    step();
    id_a = 5'd11; payload_a = 128'hA11;
    step();
    id_a = 5'd12; payload_a = 128'hA12;
    chk("bp_ready_a", ready_a, 0);
    chk("bp_head", id_c, 6'h0A);
    valid_b = 1'b1; id_b = 5'd1; qos_b = 2'd3; payload_b = 128'hB01;
    step();
    valid_b = 1'b0;
    chk("bp_lock_id", id_c, 6'h0A);
    chk("bp_lock_payload", payload_c, 128'hA10);
    rel(6'h15);
    chk("err_set", err_rel, 1);
    #2 rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    chk("async_valid_c", valid_c, 0);
    chk("async_ready_a", ready_a, 1);
    chk("async_err_rel", err_rel, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    compare_all();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      int r;
      int outs[$];
      if (c % 700 == 699) do_reset();
      if (!valid_a || pushed_a) begin
        valid_a = $urandom_range(0, 9) < 6;
        id_a = 5'($urandom_range(0, 3));
        qos_a = 2'($urandom_range(0, 3));
        payload_a = {$urandom, $urandom, $urandom, $urandom};
      end
      if (!valid_b || pushed_b) begin
        valid_b = $urandom_range(0, 9) < 6;
        id_b = 5'($urandom_range(0, 3));
        qos_b = 2'($urandom_range(0, 3));
        payload_b = {$urandom, $urandom, $urandom, $urandom};
      end
      ready_c = $urandom_range(0, 9) < 7;
      conflict_c = $urandom_range(0, 9) == 0;
      release_c = 1'b0;
      r = $urandom_range(0, 99);
      if (r < 40) begin
        for (int i = 0; i < 2*NID; i++) if (m_out[i]) outs.push_back(i);
        if (outs.size() > 0) begin
          release_c = 1'b1;
          releaseid_c = 6'(outs[$urandom_range(0, outs.size() - 1)]);
        end
      end else if (r == 99) begin
        release_c = 1'b1;
        releaseid_c = 6'($urandom_range(0, 2*NID - 1));
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/enigma_arb2.md
Name: enigma_arb2

Overview:
- Two-port request merger that sits between producer ports A and B and the single consumer port C.
- Buffers each input in a small FIFO and selects a head by QoS, with round-robin on ties.
- Tags each output beat with its source in id_c = {src, id}.
- Tracks outstanding tagged IDs so that no second beat with an in-flight ID is issued until downstream releases it; a downstream conflict causes a replay.

Parameters:
- FIFO_DEPTH, 2, entries per input FIFO; power of 2, at least 2.
- DW, 128, payload width.
- IDW, 5, input ID width; output ID width is IDW+1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- payload_a  in  DW  port A payload
- id_a  in  IDW  port A ID
- qos_a  in  2  port A QoS; 3 is highest
- valid_a  in  1  port A valid
- ready_a  out  1  port A ready
- payload_b, id_b, qos_b, valid_b, ready_b: same as port A, for port B
- payload_c  out  DW  output payload
- id_c  out  IDW+1  {src, id}; src 0 = A, 1 = B
- qos_c  out  2  output QoS
- valid_c  out  1  output valid
- ready_c  in  1  downstream ready
- conflict_c  in  1  downstream rejects the beat in the current handshake
- release_c  in  1  downstream retires an ID
- releaseid_c  in  IDW+1  ID being retired
- err_rel  out  1  sticky flag: release of an ID that is not outstanding

Behaviour:
- Reset state (asynchronous): FIFOs empty, outstanding table all 0, grant unlocked, RR pointer favours A, masks clear. Outputs: ready_a = ready_b = 1, valid_c = 0, payload_c/id_c/qos_c = 0, err_rel = 0.
- Input push: valid_x & ready_x. ready_x = !full_x, registered.
- Full FIFO: ready_x = 0; port must hold its beat.
- Simultaneous pop and push on a full FIFO: not accepted that cycle (ready is computed from the registered count).
- Head eligibility for port x: FIFO nonempty, AND out_tbl[{src_x, head id}] == 0, AND mask_x == 0.
- Selection when grant is unlocked:
  - Higher qos wins.
  - Equal qos: the port not equal to last_grant wins.
  - No eligible head: valid_c = 0.
- Output drive: payload_c/id_c/qos_c/valid_c come combinationally from the selected FIFO head.
- Latency: a beat pushed at edge N on empty FIFOs appears on C during cycle N+1 (one cycle).
- Grant lock:
  - Once valid_c = 1 and !ready_c, grant_lock = 1 with grant_src stored.
  - Next cycles present the same head even if the other port now has higher qos, so C stays stable until the handshake.
- Accept = valid_c & ready_c & !conflict_c. On accept:
  - pop granted FIFO;
  - set out_tbl[id_c];
  - last_grant <= src;
  - grant unlocked.
- Conflict = valid_c & ready_c & conflict_c. On conflict:
  - no pop, no table set;
  - grant unlocked;
  - mask_src <= 1 for exactly the next cycle, so the other port may go and livelock is avoided;
  - last_grant unchanged.
- conflict_c when there is no handshake: ignored.
- Release: release_c clears out_tbl[releaseid_c] at the edge.
  - If that bit is already 0, set err_rel (sticky until reset).
  - Release and accept on the same ID in the same cycle cannot both be legal, because accept requires the bit to be 0. In that case set wins and err_rel is raised.
- Hazard: a head whose tagged ID is outstanding blocks its own port only (in-order per port). The other port proceeds.
- Reset mid-operation: all state is cleared immediately. Beats in the FIFOs and the outstanding table are lost. valid_c drops asynchronously.

Decomposition:
- Package enigma_pkg:
  - SRC_A = 0, SRC_B = 1;
  - typedef beat_t {payload, id, qos};
  - IDW / TID width constants.
- Sub-module enigma_fifo: synchronous FIFO with beat_t data, full/empty, registered count; instantiated twice.
- Arbiter, lock, masks and outstanding table live in enigma_arb2.

Test Plan:
- Single beat: A pushes id 5, qos 1, payload 0x...DEAD at edge 10, ready_c = 1 → valid_c high in cycle 11 with id_c = 0x05; out_tbl[5] set after edge 11.
- QoS priority: A qos 1 and B qos 3 presented together, ready_c = 1 → B first with id_c = 0x2?; A the next cycle.
- Round-robin: A and B both qos 2, continuous streams, distinct IDs released each cycle → C alternates A, B, A, B, starting with A after reset.
- ID hazard: A sends id 3 twice with no release → second beat held, valid_c low. B id 3 passes as id_c = 0x23. release_c with releaseid_c = 0x03 → A's second beat issues the cycle after the release.
- Conflict replay: A beat, conflict_c = 1 on handshake → A masked one cycle, and a waiting B beat issues. A replays with identical payload. Table set only on the clean accept.
- Backpressure and reset: ready_c = 0 with 3 A pushes → ready_a low after 2; C held stable while qos_b rises. Assert rst_n = 0 mid-stream → valid_c = 0 immediately, ready_a = 1; err_rel set by releasing an idle ID and cleared by reset.
